pfft_sdiv_71s_13s_seq: RTL and testbench

PFFT_SDIV_71S_13S_SEQ -- requirements
Module: pFFT_sdiv_71s_13s_seq

---
 rtl/pfft_div_pkg.sv | 18 +
 rtl/pfft_sdiv_71s_13s_seq_step.sv | 34 +++
 rtl/pfft_sdiv_71s_13s_seq.sv | 168 ++++++++++++++++
 tb/tb_pfft_sdiv_71s_13s_seq.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pfft_div_pkg.sv
// Shared definitions for the sequential signed divider.
// Holds the default operand widths, the partial-remainder width used by the
// restoring datapath, and the controller state encoding.
package pfft_div_pkg;

    localparam int DIN0_W = 71;           // signed dividend width
    localparam int DIN1_W = 13;           // signed divisor width
    localparam int DOUT_W = DIN0_W;       // signed quotient width
    localparam int REM_W  = DIN1_W + 1;   // partial remainder register width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/pfft_sdiv_71s_13s_seq_step.sv
// One restoring radix-2 division step on unsigned magnitudes.
// Ports:
//   rem_i     - partial remainder before the step (DIV_W+1 bits)
//   bit_i     - next dividend bit, MSB first
//   divisor_i - divisor magnitude
//   rem_o     - partial remainder after the step
//   qbit_o    - quotient bit produced by this step
module pFFT_sdiv_step
    import pfft_div_pkg::*;
#(
    parameter int DIV_W = DIN1_W
) (
    input  logic [DIV_W:0]   rem_i,
    input  logic             bit_i,
    input  logic [DIV_W-1:0] divisor_i,
    output logic [DIV_W:0]   rem_o,
    output logic             qbit_o
);

    logic [DIV_W:0]   shifted;
    logic [DIV_W+1:0] trial;
    logic             step_unused;

    // The incoming remainder is always below the divisor, so its top bit is
    // zero and shifting it out loses nothing.
    assign step_unused = rem_i[DIV_W];
    assign shifted     = {rem_i[DIV_W-1:0], bit_i};
    assign trial       = {1'b0, shifted} - {2'b00, divisor_i};

    // No borrow out of the trial subtract means the divisor fits.
    assign qbit_o = ~trial[DIV_W+1];
    assign rem_o  = qbit_o ? trial[DIV_W:0] : shifted;

endmodule

// File: rtl/pfft_sdiv_71s_13s_seq.sv
// Sequential signed divider: din0 / din1 with truncation toward zero.
// One restoring step per cycle on operand magnitudes, then a sign fix-up.
// Fixed latency: out_valid rises din0_WIDTH+1 edges after the accepting edge.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// CALC  | one restoring step per cycle, counter counts down to 0
// FIX   | apply signs, divide-by-zero and overflow results
// DONE  | result held with out_valid high until out_ready
//
// Ports:
//   ap_clk, ap_rst      - clock, asynchronous active-high reset
//   in_valid/in_ready   - operand handshake, din0 dividend, din1 divisor
//   out_valid/out_ready - result handshake, quot, rem, dbz, ovf
module pfft_sdiv_71s_13s_seq
    import pfft_div_pkg::*;
#(
    parameter int din0_WIDTH = DIN0_W,
    parameter int din1_WIDTH = DIN1_W,
    parameter int dout_WIDTH = DOUT_W
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [din0_WIDTH-1:0] din0,
    input  logic signed [din1_WIDTH-1:0] din1,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [dout_WIDTH-1:0] quot,
    output logic signed [din1_WIDTH-1:0] rem,
    output logic                         dbz,
    output logic                         ovf
);

    localparam int CNT_W = $clog2(din0_WIDTH);
    localparam int RW    = din1_WIDTH + 1;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [din0_WIDTH-1:0]   dvd_q;      // dividend magnitude, becomes quotient
    logic [din1_WIDTH-1:0]   dsr_q;      // divisor magnitude
    logic [RW-1:0]           prem_q;     // partial remainder
    logic [din1_WIDTH-1:0]   din0_lo_q;  // raw dividend low bits for dbz result
    logic                    neg_quot_q;
    logic                    neg_rem_q;
    logic                    dbz_pend_q;
    logic                    ovf_pend_q;

    logic [dout_WIDTH-1:0]   quot_q;
    logic [din1_WIDTH-1:0]   rem_q;
    logic                    dbz_q;
    logic                    ovf_q;
    logic                    out_valid_q;

    logic                    din0_neg;
    logic                    din1_neg;
    logic [din0_WIDTH-1:0]   din0_mag;
    logic [din1_WIDTH-1:0]   din1_mag;
    logic                    din0_is_min;
    logic                    din1_is_m1;
    logic [RW-1:0]           prem_d;
    logic                    qbit_d;
    logic [din1_WIDTH-1:0]   rem_mag;

    assign din0_neg    = din0[din0_WIDTH-1];
    assign din1_neg    = din1[din1_WIDTH-1];
    // The most negative dividend negates to itself, which read as unsigned is
    // exactly its magnitude, so no extra bit is needed.
    assign din0_mag    = din0_neg ? -din0 : din0;
    assign din1_mag    = din1_neg ? -din1 : din1;
    assign din0_is_min = (din0 == {1'b1, {(din0_WIDTH-1){1'b0}}});
    assign din1_is_m1  = &din1;

    assign rem_mag = prem_q[din1_WIDTH-1:0];

    pFFT_sdiv_step #(
        .DIV_W     (din1_WIDTH)
    ) u_step (
        .rem_i     (prem_q),
        .bit_i     (dvd_q[din0_WIDTH-1]),
        .divisor_i (dsr_q),
        .rem_o     (prem_d),
        .qbit_o    (qbit_d)
    );

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            prem_q      <= '0;
            din0_lo_q   <= '0;
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            dbz_pend_q  <= 1'b0;
            ovf_pend_q  <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        dvd_q      <= din0_mag;
                        dsr_q      <= din1_mag;
                        prem_q     <= '0;
                        din0_lo_q  <= din0[din1_WIDTH-1:0];
                        neg_quot_q <= din0_neg ^ din1_neg;
                        neg_rem_q  <= din0_neg;
                        dbz_pend_q <= (din1 == '0);
                        ovf_pend_q <= din0_is_min & din1_is_m1;
                        cnt_q      <= CNT_W'(din0_WIDTH - 1);
                        state_q    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    // Quotient bits enter at the LSB as dividend bits leave
                    // the MSB, so dvd_q ends up holding the quotient.
                    prem_q <= prem_d;
                    dvd_q  <= {dvd_q[din0_WIDTH-2:0], qbit_d};
                    if (cnt_q == '0) begin
                        state_q <= ST_FIX;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_FIX: begin
                    if (dbz_pend_q) begin
                        quot_q <= '1;
                        rem_q  <= din0_lo_q;
                        dbz_q  <= 1'b1;
                        ovf_q  <= 1'b0;
                    end else begin
                        // For the overflow case the magnitude 2^(W-1) wraps to
                        // the most negative value without any special path.
                        quot_q <= neg_quot_q ? dout_WIDTH'(-dvd_q) : dout_WIDTH'(dvd_q);
                        rem_q  <= neg_rem_q ? -rem_mag : rem_mag;
                        dbz_q  <= 1'b0;
                        ovf_q  <= ovf_pend_q;
                    end
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign quot      = quot_q;
    assign rem       = rem_q;
    assign dbz       = dbz_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pfft_sdiv_71s_13s_seq.sv
module tb_pfft_sdiv_71s_13s_seq;

    localparam int W0 = 71;
    localparam int W1 = 13;
    localparam int LAT = W0 + 1;

    logic                 ap_clk = 1'b0;
    logic                 ap_rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [W0-1:0] din0;
    logic signed [W1-1:0] din1;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [W0-1:0] quot;
    logic signed [W1-1:0] rem;
    logic                 dbz;
    logic                 ovf;

    int checks = 0;
    int errors = 0;

    always #5 ap_clk = ~ap_clk;

    pfft_sdiv_71s_13s_seq dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din0      (din0),
        .din1      (din1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .rem       (rem),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input logic [W0-1:0] obs, input logic [W0-1:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    // Reference: plain signed arithmetic with the two special cases.
    task automatic model(input logic signed [W0-1:0] a, input logic signed [W1-1:0] b,
                         output logic signed [W0-1:0] eq, output logic signed [W1-1:0] er,
                         output logic edbz, output logic eovf);
        logic signed [W0-1:0] min_v;
        logic signed [W0-1:0] b71;
        logic signed [W0-1:0] q71;
        logic signed [W0-1:0] r71;
        min_v = {1'b1, {(W0-1){1'b0}}};
        edbz  = 1'b0;
        eovf  = 1'b0;
        if (b == 0) begin
            eq   = '1;
            er   = a[W1-1:0];
            edbz = 1'b1;
        end else if (a == min_v && (&b)) begin
            eq   = min_v;
            er   = '0;
            eovf = 1'b1;
        end else begin
            b71 = b;
            q71 = a / b71;
            r71 = a % b71;
            eq  = q71;
            er  = r71[W1-1:0];
        end
    endtask

    task automatic run_op(input logic signed [W0-1:0] a, input logic signed [W1-1:0] b,
                          input int hold, input string tag);
        logic signed [W0-1:0] eq;
        logic signed [W1-1:0] er;
        logic edbz;
        logic eovf;
        int n;
        model(a, b, eq, er, edbz, eovf);
        @(negedge ap_clk);
        chk({tag, ".in_ready"}, W0'(in_ready), W0'(1));
        din0     = a;
        din1     = b;
        in_valid = 1'b1;
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        din0     = {$urandom, $urandom, $urandom};
        din1     = W1'($urandom);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge ap_clk);
            #1;
            n++;
        end
        chk({tag, ".latency"}, W0'(n), W0'(LAT));
        chk({tag, ".quot"}, quot, eq);
        chk({tag, ".rem"}, W0'(rem), W0'(er));
        chk({tag, ".dbz"}, W0'(dbz), W0'(edbz));
        chk({tag, ".ovf"}, W0'(ovf), W0'(eovf));
        if (hold > 0) begin
            chk({tag, ".busy"}, W0'(in_ready), W0'(0));
            in_valid = 1'b1;
            din0     = 71'sd12345;
            din1     = 13'sd3;
            for (int i = 0; i < hold; i++) begin
                @(posedge ap_clk);
                #1;
                chk({tag, ".hold_quot"}, quot, eq);
                chk({tag, ".hold_rem"}, W0'(rem), W0'(er));
                chk({tag, ".hold_valid"}, W0'(out_valid), W0'(1));
                chk({tag, ".hold_ready"}, W0'(in_ready), W0'(0));
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge ap_clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".valid_drop"}, W0'(out_valid), W0'(0));
        chk({tag, ".idle_ready"}, W0'(in_ready), W0'(1));
    endtask

    initial begin
        logic signed [W0-1:0] a;
        logic signed [W1-1:0] b;
        logic seen;

        ap_rst    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din0      = '0;
        din1      = '0;
        #12;
        chk("rst.quot", quot, '0);
        chk("rst.rem", W0'(rem), '0);
        chk("rst.flags", W0'({dbz, ovf, out_valid}), '0);
        #5 ap_rst = 1'b0;
        #1;
        chk("rst.in_ready", W0'(in_ready), W0'(1));

        run_op(71'sd100, 13'sd7, 0, "p100_7");
        run_op(-71'sd100, 13'sd7, 0, "n100_7");
        run_op(71'sd100, -13'sd7, 0, "p100_n7");
        a = {1'b1, {(W0-1){1'b0}}};
        run_op(a, -13'sd1, 0, "ovf");
        run_op(71'sd5, 13'sd0, 0, "dbz");
        a = {1'b0, {(W0-1){1'b1}}};
        run_op(a, -13'sd4096, 0, "max_n4096");
        run_op(71'sd100, 13'sd7, 10, "hold");

        // Reset in the middle of CALC must drop the operation.
        @(negedge ap_clk);
        din0     = 71'sd100;
        din1     = 13'sd7;
        in_valid = 1'b1;
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        repeat (30) @(posedge ap_clk);
        #2 ap_rst = 1'b1;
        #1;
        chk("midrst.quot", quot, '0);
        chk("midrst.rem", W0'(rem), '0);
        chk("midrst.flags", W0'({dbz, ovf, out_valid}), '0);
        #1 ap_rst = 1'b0;
        #1;
        chk("midrst.in_ready", W0'(in_ready), W0'(1));
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge ap_clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("midrst.no_valid", W0'(seen), W0'(0));
        run_op(71'sd100, 13'sd7, 0, "after_rst");

        for (int i = 0; i < 24; i++) begin
            a = {$urandom, $urandom, $urandom};
            b = W1'($urandom);
            case (i % 4)
                1: b = W1'($urandom_range(1, 15)) * (($urandom % 2) != 0 ? -13'sd1 : 13'sd1);
                2: a = W0'($signed($urandom_range(0, 100000))) - 71'sd50000;
                3: if (($urandom % 3) == 0) b = '0;
                default: ;
            endcase
            run_op(a, b, (i % 6 == 5) ? 3 : 0, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
